// File: rtl/lfsr_entropy_gen_if.sv
// Handshake bundle between the LFSR entropy source and its consumer.
// The slave modport is the generator side; the master modport is the consumer side.
interface lfsr_entropy_gen_if #(
    parameter int WIDTH = 128
);
    logic             load_i;
    logic [WIDTH-1:0] seed_i;
    logic [WIDTH-1:0] poly_i;
    logic [WIDTH-1:0] entropy_o;
    logic             entropy_valid_o;
    logic             entropy_ready_i;
    logic             lockup_o;
    logic [7:0]       lockup_cnt_o;

    modport master (
        output load_i, seed_i, poly_i, entropy_ready_i,
        input  entropy_o, entropy_valid_o, lockup_o, lockup_cnt_o
    );

    modport slave (
        input  load_i, seed_i, poly_i, entropy_ready_i,
        output entropy_o, entropy_valid_o, lockup_o, lockup_cnt_o
    );
endinterface

// File: rtl/lfsr_entropy_gen.sv
// Parametrised Fibonacci-style LFSR entropy source with seeding, warm-up,
// valid/ready output handshake and zero-state lockup recovery.
module lfsr_entropy_gen #(
    parameter int               WIDTH        = 128,
    parameter int               STEPS        = 1,
    parameter int               WARMUP       = 128,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic              clk,
    input  logic              rst,
    lfsr_entropy_gen_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;

    localparam int               CW        = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [CW-1:0]    WARM_LAST = CW'(WARMUP);
    localparam state_t           START     = (WARMUP == 0) ? RUN : WARM;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [CW-1:0]    warm_cnt_q, warm_cnt_d;
    logic             lockup_q, lockup_d;
    logic [7:0]       lockup_cnt_q;
    logic [WIDTH-1:0] advanced;
    logic [WIDTH-1:0] candidate;
    logic             update;
    logic [CW-1:0]    warm_inc;
    logic             entropy_valid;

    function automatic logic [WIDTH-1:0] advance_n(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] poly);
        logic [WIDTH-1:0] v;
        v = s;
        for (int i = 0; i < STEPS; i++) begin
            v = {^(poly & v), v[WIDTH-1:1]};
        end
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lfsr_q       <= '0;
            warm_cnt_q   <= '0;
            lockup_q     <= 1'b0;
            lockup_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            warm_cnt_q <= warm_cnt_d;
            lockup_q   <= lockup_d;
            if (lockup_d && (lockup_cnt_q != 8'hFF)) begin
                lockup_cnt_q <= lockup_cnt_q + 8'd1;
            end
        end
    end

    // The guard inspects whatever is about to be registered, so a zero seed
    // and a zero-producing advance recover through the same path.
    always_comb begin
        advanced   = advance_n(lfsr_q, bus.poly_i);
        warm_inc   = warm_cnt_q + CW'(1);
        update     = 1'b0;
        candidate  = lfsr_q;
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;

        if (bus.load_i) begin
            update     = 1'b1;
            candidate  = bus.seed_i;
            state_d    = START;
            warm_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                WARM: begin
                    update     = 1'b1;
                    candidate  = advanced;
                    warm_cnt_d = warm_inc;
                    if (warm_inc == WARM_LAST) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.entropy_ready_i) begin
                        update    = 1'b1;
                        candidate = advanced;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        lockup_d = update && (candidate == '0);
        lfsr_d   = candidate;
        if (lockup_d) begin
            lfsr_d     = DEFAULT_SEED;
            state_d    = START;
            warm_cnt_d = '0;
        end
    end

    always_comb begin
        entropy_valid = (state_q == RUN);
    end

    assign bus.entropy_o       = lfsr_q;
    assign bus.entropy_valid_o = entropy_valid;
    assign bus.lockup_o        = lockup_q;
    assign bus.lockup_cnt_o    = lockup_cnt_q;

endmodule

// File: tb/tb_lfsr_entropy_gen.sv
// Four 8-bit generators with different STEPS/WARMUP share one stimulus stream
// and are compared every cycle against an abstract model of the source.
module tb_lfsr_entropy_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [7:0] poly = 8'h00;
    logic       ready = 1'b0;

    logic [3:0][7:0] ent;
    logic [3:0][7:0] cnt;
    logic [3:0]      val;
    logic [3:0]      lck;

    int vectors = 0;
    int miscompares = 0;

    int         m_steps [4] = '{1, 2, 1, 3};
    int         m_warm  [4] = '{0, 0, 4, 5};
    logic [7:0] m_state [4];
    int         m_left  [4];
    bit         m_active[4];
    bit         m_lock  [4];
    int         m_cnt   [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int S = (g == 1) ? 2 : (g == 3) ? 3 : 1;
        localparam int W = (g == 2) ? 4 : (g == 3) ? 5 : 0;
        lfsr_entropy_gen_if #(.WIDTH(8)) bus ();
        assign bus.load_i          = load;
        assign bus.seed_i          = seed;
        assign bus.poly_i          = poly;
        assign bus.entropy_ready_i = ready;
        assign ent[g] = bus.entropy_o;
        assign val[g] = bus.entropy_valid_o;
        assign lck[g] = bus.lockup_o;
        assign cnt[g] = bus.lockup_cnt_o;
        lfsr_entropy_gen #(.WIDTH(8), .STEPS(S), .WARMUP(W), .DEFAULT_SEED(8'h01)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One shift: new MSB is the parity of the tapped bits, everything else moves down.
    function automatic logic [7:0] model_adv(input logic [7:0] s, input logic [7:0] p, input int n);
        logic [7:0] v;
        v = s;
        for (int i = 0; i < n; i++) begin
            v = ($countones(v & p) % 2 == 1) ? ((v >> 1) | 8'h80) : (v >> 1);
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_state[k] = 8'h00; m_left[k] = 0; m_active[k] = 0; m_lock[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            logic [7:0] cand;
            bit         upd;
            int         left_n;
            upd = 0; cand = m_state[k]; left_n = m_left[k];
            if (load) begin
                upd = 1; cand = seed; left_n = m_warm[k]; m_active[k] = 1;
            end else if (m_active[k] && m_left[k] > 0) begin
                upd = 1; cand = model_adv(m_state[k], poly, m_steps[k]); left_n = m_left[k] - 1;
            end else if (m_active[k] && ready) begin
                upd = 1; cand = model_adv(m_state[k], poly, m_steps[k]);
            end
            m_lock[k] = 0;
            if (upd && cand == 8'h00) begin
                cand = 8'h01; left_n = m_warm[k]; m_lock[k] = 1;
                if (m_cnt[k] < 255) m_cnt[k]++;
            end
            m_state[k] = cand;
            m_left[k]  = left_n;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("entropy[%0d]", k), 32'(ent[k]), 32'(m_state[k]));
            checkOutput($sformatf("valid[%0d]", k), 32'(val[k]), 32'(m_active[k] && m_left[k] == 0));
            checkOutput($sformatf("lockup[%0d]", k), 32'(lck[k]), 32'(m_lock[k]));
            checkOutput($sformatf("lockup_cnt[%0d]", k), 32'(cnt[k]), 32'(m_cnt[k]));
        end
    endtask

    task automatic applyStimulus();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] exp_s1[6] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
    logic [7:0] exp_s2[3] = '{8'h01, 8'h40, 8'h10};

    initial begin
        #1;
        do_reset();

        // Basic sequence, multi-step and warm-up observed together.
        load = 1; seed = 8'h01; poly = 8'h1D; ready = 1;
        applyStimulus();
        load = 0;
        for (int t = 0; t < 6; t++) begin
            checkOutput("basic_s1", 32'(ent[0]), 32'(exp_s1[t]));
            if (t < 3) checkOutput("basic_s2", 32'(ent[1]), 32'(exp_s2[t]));
            checkOutput("warm_valid", 32'(val[2]), 32'(t >= 4));
            if (t == 4) checkOutput("warm_word", 32'(ent[2]), 32'h10);
            if (t < 5) applyStimulus();
        end

        // Backpressure: words hold and valid stays high.
        ready = 0;
        for (int t = 0; t < 3; t++) begin
            applyStimulus();
            checkOutput("hold_valid", 32'(val[1]), 32'd1);
        end
        ready = 1;
        applyStimulus();

        // Reload on the third warm cycle restarts the warm-up count.
        load = 1; seed = 8'h01;
        applyStimulus();
        load = 0;
        applyStimulus();
        applyStimulus();
        load = 1;
        applyStimulus();
        load = 0;
        for (int t = 0; t < 5; t++) begin
            checkOutput("rewarm_valid", 32'(val[2]), 32'(t == 4));
            if (t < 4) applyStimulus();
        end
        checkOutput("rewarm_word", 32'(ent[2]), 32'h10);

        // Load colliding with a handshake takes the seed.
        ready = 1; load = 1; seed = 8'h5A;
        applyStimulus();
        load = 0;
        checkOutput("collision", 32'(ent[0]), 32'h5A);

        // Reset mid-run, then idle without a load.
        applyStimulus();
        do_reset();
        for (int t = 0; t < 20; t++) begin
            applyStimulus();
            checkOutput("idle_valid", 32'(val[2]), 32'd0);
        end

        // Lockup handling and counter saturation.
        load = 1; seed = 8'h01; poly = 8'hB8; ready = 0;
        applyStimulus();
        load = 0; ready = 1;
        applyStimulus();
        checkOutput("lock_word", 32'(ent[0]), 32'h01);
        checkOutput("lock_pulse", 32'(lck[0]), 32'd1);
        checkOutput("lock_cnt1", 32'(cnt[0]), 32'd1);
        ready = 0;
        applyStimulus();
        checkOutput("lock_clear", 32'(lck[0]), 32'd0);
        load = 1; seed = 8'h00;
        applyStimulus();
        load = 0;
        checkOutput("zero_seed_pulse", 32'(lck[0]), 32'd1);
        checkOutput("zero_seed_cnt", 32'(cnt[0]), 32'd2);
        ready = 1;
        for (int t = 0; t < 300; t++) applyStimulus();
        checkOutput("lock_saturate", 32'(cnt[0]), 32'd255);

        // Randomised traffic, with one reset part-way through.
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            load  = ($urandom_range(15) == 0);
            seed  = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(31) == 0) poly = 8'($urandom);
            ready = ($urandom_range(9) < 7);
            applyStimulus();
            if (t == 700) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
